// File: rtl/flag_bank_arbiter.sv
// Shared SR status-flag bank written by NREQ requesters through a
// round-robin arbiter that accepts at most one set/clear per cycle.
module flag_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDX_W = 3,
  parameter int RQ_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_all,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [IDX_W*NREQ-1:0]   req_idx,
  output logic [NREQ-1:0]         req_ready,
  output logic [NFLAG-1:0]        flags,
  output logic                    upd_valid,
  output logic [RQ_W-1:0]         upd_id,
  output logic                    upd_err
);

  logic [NFLAG-1:0] flags_q, flags_d;
  logic [RQ_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             upd_valid_q, upd_valid_d;
  logic [RQ_W-1:0]  upd_id_q, upd_id_d;
  logic             upd_err_q, upd_err_d;

  logic             grant;
  logic [RQ_W-1:0]  win_id;
  logic [1:0]       win_op;
  logic [IDX_W-1:0] win_idx;
  logic             idx_ok;
  int               scan_c;

  // Rotating priority scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    grant     = 1'b0;
    win_id    = '0;
    scan_c    = 0;
    req_ready = '0;
    if (!reset && !clr_all) begin
      for (int k = 0; k < NREQ; k++) begin
        scan_c = int'(rr_ptr_q) + k;
        if (scan_c >= NREQ) scan_c = scan_c - NREQ;
        if (!grant && req_valid[scan_c]) begin
          grant  = 1'b1;
          win_id = RQ_W'(scan_c);
        end
      end
    end
    if (grant) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    win_op  = req_op[2*int'(win_id) +: 2];
    win_idx = req_idx[IDX_W*int'(win_id) +: IDX_W];
    idx_ok  = (int'(win_idx) < NFLAG);
  end

  always_comb begin
    flags_d     = flags_q;
    rr_ptr_d    = rr_ptr_q;
    upd_valid_d = grant;
    upd_id_d    = upd_id_q;
    upd_err_d   = 1'b0;
    if (clr_all) begin
      flags_d = '0;
    end else if (grant) begin
      if (idx_ok) begin
        case (win_op)
          2'b01:   flags_d[win_idx] = 1'b0;
          2'b10:   flags_d[win_idx] = 1'b1;
          default: flags_d = flags_q;
        endcase
      end
      upd_id_d  = win_id;
      upd_err_d = (win_op == 2'b11) || !idx_ok;
      if (int'(win_id) == NREQ - 1) rr_ptr_d = '0;
      else                          rr_ptr_d = win_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= '0;
      rr_ptr_q    <= '0;
      upd_valid_q <= 1'b0;
      upd_id_q    <= '0;
      upd_err_q   <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      rr_ptr_q    <= rr_ptr_d;
      upd_valid_q <= upd_valid_d;
      upd_id_q    <= upd_id_d;
      upd_err_q   <= upd_err_d;
    end
  end

  assign flags     = flags_q;
  assign upd_valid = upd_valid_q;
  assign upd_id    = upd_id_q;
  assign upd_err   = upd_err_q;

endmodule

// File: tb/tb_flag_bank_arbiter.sv
// Directed bench for flag_bank_arbiter: default bank plus a 6-flag bank
// sharing the same stimulus to reach the out-of-range index case.
module tb_flag_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_all;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [11:0] req_idx;

  logic [3:0]  req_ready;
  logic [7:0]  flags;
  logic        upd_valid;
  logic [1:0]  upd_id;
  logic        upd_err;

  logic [3:0]  req_ready6;
  logic [5:0]  flags6;
  logic        upd_valid6;
  logic [1:0]  upd_id6;
  logic        upd_err6;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  flag_bank_arbiter #(.NREQ(4), .NFLAG(8), .IDX_W(3), .RQ_W(2)) u_dut (
    .clk(clk), .reset(reset), .clr_all(clr_all),
    .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_ready(req_ready), .flags(flags),
    .upd_valid(upd_valid), .upd_id(upd_id), .upd_err(upd_err)
  );

  flag_bank_arbiter #(.NREQ(4), .NFLAG(6), .IDX_W(3), .RQ_W(2)) u_dut6 (
    .clk(clk), .reset(reset), .clr_all(clr_all),
    .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_ready(req_ready6), .flags(flags6),
    .upd_valid(upd_valid6), .upd_id(upd_id6), .upd_err(upd_err6)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [2:0] idx);
    req_valid[i]       = v;
    req_op[2*i +: 2]   = op;
    req_idx[3*i +: 3]  = idx;
  endtask

  task automatic chk_upd(input string tag, input logic [7:0] f, input logic v,
                         input logic [1:0] id, input logic e);
    chk({tag, "_flags"}, 64'(flags), 64'(f));
    chk({tag, "_uv"},    64'(upd_valid), 64'(v));
    chk({tag, "_uid"},   64'(upd_id), 64'(id));
    chk({tag, "_uerr"},  64'(upd_err), 64'(e));
  endtask

  initial begin
    reset = 1'b1; clr_all = 1'b0; req_valid = '0; req_op = '0; req_idx = '0;
    set_req(0, 1'b1, 2'b10, 3'd1);
    #1;
    chk("rst_ready_forced", 64'(req_ready), 64'h0);
    step(); step();
    chk_upd("rst", 8'h00, 1'b0, 2'd0, 1'b0);
    set_req(0, 1'b0, 2'b00, 3'd0);
    reset = 1'b0;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("idle_ready", 64'(req_ready), 64'h0);
      step();
      chk_upd("idle", 8'h00, 1'b0, 2'd0, 1'b0);
    end

    // Single set then clear
    set_req(0, 1'b1, 2'b10, 3'd5);
    #1;
    chk("set_ready", 64'(req_ready), 64'h1);
    step();
    chk_upd("set5", 8'h20, 1'b1, 2'd0, 1'b0);
    set_req(0, 1'b1, 2'b01, 3'd5);
    #1;
    chk("clr_ready", 64'(req_ready), 64'h1);
    step();
    chk_upd("clr5", 8'h00, 1'b1, 2'd0, 1'b0);
    set_req(0, 1'b0, 2'b00, 3'd0);
    step();
    chk_upd("after_clr", 8'h00, 1'b0, 2'd0, 1'b0);

    // Reset pulse returns rr_ptr to 0, then round-robin over all four
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'b10, 3'(i));
    #1; chk("rr_ready0", 64'(req_ready), 64'h1); step();
    chk_upd("rr0", 8'h01, 1'b1, 2'd0, 1'b0);
    #1; chk("rr_ready1", 64'(req_ready), 64'h2); step();
    chk_upd("rr1", 8'h03, 1'b1, 2'd1, 1'b0);
    #1; chk("rr_ready2", 64'(req_ready), 64'h4); step();
    chk_upd("rr2", 8'h07, 1'b1, 2'd2, 1'b0);
    #1; chk("rr_ready3", 64'(req_ready), 64'h8); step();
    chk_upd("rr3", 8'h0F, 1'b1, 2'd3, 1'b0);
    #1; chk("rr_ready_wrap", 64'(req_ready), 64'h1); step();
    chk_upd("rr_wrap", 8'h0F, 1'b1, 2'd0, 1'b0);

    // Move rr_ptr to 3 via a hold op from requester 2
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 2'b00, 3'd0);
    set_req(2, 1'b1, 2'b00, 3'd0);
    #1; chk("hold_ready", 64'(req_ready), 64'h4); step();
    chk_upd("hold", 8'h0F, 1'b1, 2'd2, 1'b0);
    set_req(2, 1'b0, 2'b00, 3'd0);
    set_req(3, 1'b1, 2'b01, 3'd3);
    set_req(1, 1'b1, 2'b01, 3'd1);
    #1; chk("ptr3_ready", 64'(req_ready), 64'h8); step();
    chk_upd("ptr3_r3", 8'h07, 1'b1, 2'd3, 1'b0);
    set_req(3, 1'b0, 2'b00, 3'd0);
    #1; chk("ptr0_ready", 64'(req_ready), 64'h2); step();
    chk_upd("ptr0_r1", 8'h05, 1'b1, 2'd1, 1'b0);
    set_req(1, 1'b0, 2'b00, 3'd0);

    // Illegal op and out-of-range index
    set_req(2, 1'b1, 2'b11, 3'd2);
    #1; chk("err11_ready", 64'(req_ready), 64'h4); step();
    chk_upd("err11", 8'h05, 1'b1, 2'd2, 1'b1);
    set_req(2, 1'b0, 2'b00, 3'd0);
    set_req(1, 1'b1, 2'b10, 3'd7);
    #1; chk("oor_ready6", 64'(req_ready6), 64'h2); step();
    chk("oor_flags6", 64'(flags6), 64'h05);
    chk("oor_uerr6",  64'(upd_err6), 64'h1);
    chk("oor_uv6",    64'(upd_valid6), 64'h1);
    chk("oor_uid6",   64'(upd_id6), 64'h1);
    chk_upd("idx7_in8", 8'h85, 1'b1, 2'd1, 1'b0);
    set_req(1, 1'b0, 2'b00, 3'd0);

    // Fill to 0xFF, then clr_all beats a pending request
    for (int k = 0; k < 8; k++) begin
      set_req(0, 1'b1, 2'b10, 3'(k));
      step();
    end
    chk("fill_ff", 64'(flags), 64'hFF);
    clr_all = 1'b1;
    set_req(0, 1'b1, 2'b01, 3'd0);
    #1; chk("clrall_ready", 64'(req_ready), 64'h0); step();
    chk_upd("clrall", 8'h00, 1'b0, 2'd0, 1'b0);
    clr_all = 1'b0;
    set_req(0, 1'b1, 2'b10, 3'd4);
    #1; chk("post_clr_ready", 64'(req_ready), 64'h1); step();
    chk_upd("post_clr", 8'h10, 1'b1, 2'd0, 1'b0);
    set_req(0, 1'b0, 2'b00, 3'd0);

    // Reset while requester 3 is granted
    set_req(3, 1'b1, 2'b10, 3'd6);
    #1; chk("mid_ready", 64'(req_ready), 64'h8);
    reset = 1'b1;
    #1; chk("mid_rst_ready", 64'(req_ready), 64'h0);
    step();
    chk_upd("mid_rst", 8'h00, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    set_req(1, 1'b1, 2'b10, 3'd2);
    #1; chk("post_rst_ready", 64'(req_ready), 64'h2); step();
    chk_upd("post_rst", 8'h04, 1'b1, 2'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
